// File: rtl/s_store_pkg.sv
// Shared types for the S-bus store path.
// State encoding and bus widths shared with the load-path blocks.
package s_store_pkg;

    localparam int S_DATA_W = 16;
    localparam int S_ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        REL  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } st_state_t;

endpackage

// File: rtl/s_store_timer.sv
// Wait-state timer for the store handshake.
// Saturating up-counter; expire flags the last allowed REQ cycle.
module s_store_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clr,
    input  logic                            en,
    input  logic                            load,
    input  logic [$clog2(TIMEOUT+1)-1:0]    load_val,
    output logic                            expire
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != T_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == T_LAST);

endmodule

// File: rtl/s_store_unit.sv
// Store-path sequencer: drives one S-bus word into data memory
// over a four-phase req/ack handshake with a wait-state timeout.
module s_store_unit
    import s_store_pkg::*;
#(
    parameter int DATA_W  = S_DATA_W,
    parameter int ADDR_W  = S_ADDR_W,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_start,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] S,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    output logic              st_busy,
    output logic              st_done,
    output logic              st_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    st_state_t state;
    st_state_t state_nx;

    logic t_clr;
    logic t_en;
    logic t_exp;
    logic take;

    s_store_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (t_clr),
        .en       (t_en),
        .load     (1'b0),
        .load_val ({TW{1'b0}}),
        .expire   (t_exp)
    );

    // Ack is checked before expiry so a late ack still completes.
    always_comb begin
        state_nx = state;
        t_clr    = 1'b0;
        t_en     = 1'b0;
        take     = 1'b0;
        unique case (state)
            IDLE: begin
                if (st_start) begin
                    state_nx = REQ;
                    t_clr    = 1'b1;
                    take     = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_nx = REL;
                end else if (t_exp) begin
                    state_nx = ERR;
                end else begin
                    t_en = 1'b1;
                end
            end
            REL: begin
                if (!mem_ack) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            st_busy   <= 1'b0;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state   <= state_nx;
            mem_req <= (state_nx == REQ);
            mem_we  <= (state_nx == REQ);
            st_busy <= (state_nx != IDLE);
            st_done <= (state_nx == DONE);
            st_err  <= (state_nx == ERR);
            if (take) begin
                mem_addr  <= st_addr;
                mem_wdata <= S;
            end
        end
    end

endmodule
